// File: rtl/dither_pkg.sv
// Shared definitions for the colour dither stage: mode encoding and the
// 2x2 ordered-dither threshold table.
package dither_pkg;

  typedef enum logic [1:0] {
    BYPASS  = 2'd0,
    ORDERED = 2'd1,
    ERRDIFF = 2'd2
  } dither_mode_e;

  // Bayer matrix indexed [row][col]
  localparam logic [1:0] BAYER [0:1][0:1] = '{'{2'd0, 2'd2}, '{2'd3, 2'd1}};

  // Mode code 3 is unassigned and behaves as bypass
  function automatic dither_mode_e decode_mode(input logic [1:0] code);
    dither_mode_e m;
    case (code)
      2'd1:    m = ORDERED;
      2'd2:    m = ERRDIFF;
      default: m = BYPASS;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dither_channel.sv
// One colour channel of the dither stage: offset/error addition, clipping,
// requantisation and the per-channel error-diffusion register.
module dither_channel
  import dither_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_p0,
  input  logic             vis_p0,
  input  logic [1:0]       mode_p0,
  input  logic             row_p0,
  input  logic             col_p0,
  input  logic             clr_p0,
  input  logic [IN_W-1:0]  din_p0,
  output logic [OUT_W-1:0] dout_p1
);

  localparam int D = IN_W - OUT_W;
  localparam logic [IN_W:0] MAX_V = {1'b0, {IN_W{1'b1}}};

  dither_mode_e    mode_e;
  logic [D-1:0]    err_q;
  logic [D-1:0]    err_use;
  logic [IN_W:0]   addend;
  logic [IN_W:0]   sum;
  logic            sat;
  logic [IN_W-1:0] clipped;

  function automatic logic is_sat(input logic [IN_W:0] s);
    return s > MAX_V;
  endfunction

  function automatic logic [IN_W-1:0] clip(input logic [IN_W:0] s);
    return (s > MAX_V) ? MAX_V[IN_W-1:0] : s[IN_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] v);
    return v[IN_W-1 -: OUT_W];
  endfunction

  assign mode_e = dither_mode_e'(mode_p0);

  // Per-mode addend; line/frame starts see a zero carried error
  always_comb begin
    err_use = clr_p0 ? '0 : err_q;
    case (mode_e)
      ORDERED: addend = (IN_W+1)'(BAYER[row_p0][col_p0]) << (D - 2);
      ERRDIFF: addend = (IN_W+1)'(err_use);
      default: addend = '0;
    endcase
    sum     = {1'b0, din_p0} + addend;
    sat     = is_sat(sum);
    clipped = clip(sum);
  end

  // Error feedback advances only on valid visible error-diffusion pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (vld_p0 && vis_p0 && (mode_e == ERRDIFF)) begin
      err_q <= sat ? '0 : sum[D-1:0];
    end
  end

  // ---- stage 1: output register, blanked outside valid visible pixels ----
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1 <= '0;
    end else begin
      dout_p1 <= (vld_p0 && vis_p0) ? requant(clipped) : '0;
    end
  end

endmodule

// File: rtl/color_dither_stage.sv
// Two-stage colour dither: bypass truncation, 2x2 ordered dither or
// horizontal error diffusion, reducing IN_W to OUT_W bits per channel.
// IN_W - OUT_W must be at least 2 for the ordered offset shift.
module color_dither_stage
  import dither_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  input  logic                    in_visible,
  input  logic                    in_sol,
  input  logic                    in_sof,
  input  logic [NUM_CH*IN_W-1:0]  data_in,
  output logic                    out_valid,
  output logic                    out_visible,
  output logic [NUM_CH*OUT_W-1:0] data_out
);

  dither_mode_e            mode_q;
  dither_mode_e            mode_cur;
  dither_mode_e            mode_p0;
  logic                    row_q;
  logic                    col_q;
  logic                    row_cur;
  logic                    col_cur;
  logic                    vld_p0;
  logic                    vis_p0;
  logic                    row_p0;
  logic                    col_p0;
  logic                    clr_p0;
  logic [NUM_CH*IN_W-1:0]  data_p0;

  // Parity and mode as seen by the incoming pixel (sof/sol take effect on it)
  always_comb begin
    mode_cur = mode_q;
    row_cur  = row_q;
    col_cur  = col_q;
    if (in_valid && in_sof) begin
      mode_cur = decode_mode(mode);
      row_cur  = 1'b0;
    end else if (in_valid && in_sol) begin
      row_cur  = ~row_q;
    end
    if (in_valid && in_sol) begin
      col_cur = 1'b0;
    end
  end

  // Frame/line state: latched mode, row parity, next column parity
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= BYPASS;
      row_q  <= 1'b0;
      col_q  <= 1'b0;
    end else if (in_valid) begin
      mode_q <= mode_cur;
      row_q  <= row_cur;
      col_q  <= ~col_cur;
    end
  end

  // ---- stage 0: capture pixel with its resolved position and mode ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      vis_p0  <= 1'b0;
      mode_p0 <= BYPASS;
      row_p0  <= 1'b0;
      col_p0  <= 1'b0;
      clr_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0  <= in_valid;
      vis_p0  <= in_visible;
      mode_p0 <= mode_cur;
      row_p0  <= row_cur;
      col_p0  <= col_cur;
      clr_p0  <= in_sol | in_sof;
      data_p0 <= data_in;
    end
  end

  // ---- stage 1: output strobes (channel data registered in each channel) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_visible <= 1'b0;
    end else begin
      out_valid   <= vld_p0;
      out_visible <= vis_p0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dither_channel #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .vld_p0  (vld_p0),
      .vis_p0  (vis_p0),
      .mode_p0 (mode_p0),
      .row_p0  (row_p0),
      .col_p0  (col_p0),
      .clr_p0  (clr_p0),
      .din_p0  (data_p0[g*IN_W +: IN_W]),
      .dout_p1 (data_out[g*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_color_dither_stage.sv
// Testbench for color_dither_stage (NUM_CH=3, IN_W=8, OUT_W=4).
module tb_color_dither_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_visible;
  logic        in_sol;
  logic        in_sof;
  logic [23:0] data_in;
  logic        out_valid;
  logic        out_visible;
  logic [11:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  color_dither_stage #(.NUM_CH(3), .IN_W(8), .OUT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_visible  (in_visible),
    .in_sol      (in_sol),
    .in_sof      (in_sof),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_visible (out_visible),
    .data_out    (data_out)
  );

  // Reference model state (plain integers)
  int m_mode, m_row, m_col;
  int m_err [3];
  int bay [2][2] = '{'{0, 2}, '{3, 1}};

  logic        pend_v, pend_s, exp_v, exp_s;
  logic [11:0] pend_d, exp_d;

  // Apply one cycle of input, advance the model, step to the next negedge.
  // Afterwards exp_* hold what the outputs should show now.
  task automatic drive(input logic r, input logic v, input logic vis,
                       input logic sol, input logic sof,
                       input logic [1:0] md, input logic [23:0] d);
    logic [11:0] nd;
    int x, s, e, y;
    rst = r; in_valid = v; in_visible = vis; in_sol = sol; in_sof = sof;
    mode = md; data_in = d;
    nd = '0;
    if (!r && v) begin
      if (sof) begin
        m_mode = (md == 2'd3) ? 0 : int'(md);
        m_row  = 0;
      end else if (sol) begin
        m_row = 1 - m_row;
      end
      if (sol) m_col = 0;
      for (int ch = 0; ch < 3; ch++) begin
        x = int'(d[ch*8 +: 8]);
        case (m_mode)
          1: begin
            s = x + bay[m_row][m_col] * 4;
            y = ((s > 255) ? 255 : s) / 16;
          end
          2: begin
            e = (sol || sof) ? 0 : m_err[ch];
            s = x + e;
            if (s > 255) begin
              y = 15;
              if (vis) m_err[ch] = 0;
            end else begin
              y = s / 16;
              if (vis) m_err[ch] = s % 16;
            end
          end
          default: y = x / 16;
        endcase
        if (vis) nd[ch*4 +: 4] = 4'(y);
      end
      m_col = 1 - m_col;
    end
    @(posedge clk);
    @(negedge clk);
    if (r) begin
      m_mode = 0; m_row = 0; m_col = 0;
      for (int ch = 0; ch < 3; ch++) m_err[ch] = 0;
      exp_v = 1'b0; exp_s = 1'b0; exp_d = '0;
      pend_v = 1'b0; pend_s = 1'b0; pend_d = '0;
    end else begin
      exp_v = pend_v; exp_s = pend_s; exp_d = pend_d;
      pend_v = v; pend_s = vis; pend_d = v ? nd : 12'h000;
    end
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1, 2'd2, 24'hFFFFFF);
    drive(1, 1, 1, 0, 0, 2'd2, 24'h123456);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_visible !== 1'b0) begin errors++; $display("FAIL reset_visible got=%b want=0", out_visible); end
    checks++; if (data_out !== 12'h000) begin errors++; $display("FAIL reset_data got=%h want=000", data_out); end
    drive(0, 0, 0, 0, 0, 2'd0, 24'h0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_bypass();
    drive(0, 1, 1, 1, 1, 2'd0, 24'hF0_87_12);
    drive(0, 0, 0, 0, 0, 2'd0, 24'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%b want=1", out_valid); end
    checks++; if (out_visible !== 1'b1) begin errors++; $display("FAIL bypass_visible got=%b want=1", out_visible); end
    checks++; if (data_out !== 12'hF81) begin errors++; $display("FAIL bypass_data got=%h want=F81", data_out); end
  endtask

  task automatic test_errdiff();
    logic [3:0] w;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(0, 1, 1, i == 0, i == 0, 2'd2, {3{8'h08}});
      else       drive(0, 0, 0, 0, 0, 2'd2, 24'h0);
      if (i > 0) begin
        w = 4'((i - 1) % 2);
        checks++;
        if (out_valid !== 1'b1 || data_out !== {w, w, w}) begin
          errors++;
          $display("FAIL errdiff[%0d] got valid=%b data=%h want valid=1 data=%h", i - 1, out_valid, data_out, {w, w, w});
        end
      end
    end
  endtask

  task automatic test_ordered();
    logic [3:0] want [4] = '{4'd0, 4'd1, 4'd1, 4'd0};
    logic       sol_s [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       sof_s [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] w;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(0, 1, 1, sol_s[i], sof_s[i], 2'd1, {3{8'h08}});
      else       drive(0, 0, 0, 0, 0, 2'd1, 24'h0);
      if (i > 0) begin
        w = want[i - 1];
        checks++;
        if (data_out !== {w, w, w}) begin
          errors++;
          $display("FAIL ordered[%0d] got=%h want=%h", i - 1, data_out, {w, w, w});
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] px [3]   = '{8'hF8, 8'hFF, 8'h0F};
    logic [3:0] want [3] = '{4'd15, 4'd15, 4'd0};
    logic [3:0] w;
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) drive(0, 1, 1, i == 0, i == 0, 2'd2, {3{px[i]}});
      else       drive(0, 0, 0, 0, 0, 2'd2, 24'h0);
      if (i > 0) begin
        w = want[i - 1];
        checks++;
        if (data_out !== {w, w, w}) begin
          errors++;
          $display("FAIL saturation[%0d] got=%h want=%h", i - 1, data_out, {w, w, w});
        end
      end
    end
  endtask

  task automatic test_gating();
    drive(0, 1, 1, 1, 1, 2'd2, {3{8'h08}});
    drive(0, 1, 0, 0, 0, 2'd2, {3{8'h08}});
    checks++; if (data_out !== 12'h000) begin errors++; $display("FAIL gate_first got=%h want=000", data_out); end
    drive(0, 0, 1, 0, 0, 2'd2, {3{8'hFF}});
    checks++;
    if (out_visible !== 1'b0 || data_out !== 12'h000) begin
      errors++;
      $display("FAIL gate_invisible got vis=%b data=%h want vis=0 data=000", out_visible, data_out);
    end
    drive(0, 1, 1, 0, 0, 2'd2, {3{8'h08}});
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gate_hole got=%b want=0", out_valid); end
    drive(0, 0, 0, 0, 0, 2'd2, 24'h0);
    checks++; if (data_out !== 12'h111) begin errors++; $display("FAIL gate_err_held got=%h want=111", data_out); end
  endtask

  task automatic test_reset_midline();
    drive(0, 1, 1, 1, 1, 2'd2, {3{8'h08}});
    drive(0, 1, 1, 0, 0, 2'd2, {3{8'h08}});
    drive(1, 1, 1, 0, 0, 2'd2, {3{8'h08}});
    checks++;
    if (out_valid !== 1'b0 || out_visible !== 1'b0 || data_out !== 12'h000) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b s=%b d=%h want 0 0 000", out_valid, out_visible, data_out);
    end
    drive(0, 1, 1, 0, 0, 2'd2, {3{8'h08}});
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_flush got=%b want=0", out_valid); end
    drive(0, 1, 1, 0, 0, 2'd2, {3{8'h08}});
    checks++;
    if (out_valid !== 1'b1 || data_out !== 12'h000) begin
      errors++;
      $display("FAIL midreset_first got v=%b d=%h want 1 000", out_valid, data_out);
    end
    drive(0, 0, 0, 0, 0, 2'd2, 24'h0);
    checks++; if (data_out !== 12'h000) begin errors++; $display("FAIL midreset_bypass got=%h want=000", data_out); end
  endtask

  task automatic test_mode_change();
    logic [1:0] md [8]   = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    logic       sol_s [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       sof_s [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] want [8] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0};
    logic [3:0] w;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(0, 1, 1, sol_s[i], sof_s[i], md[i], {3{8'h08}});
      else       drive(0, 0, 0, 0, 0, 2'd1, 24'h0);
      if (i > 0) begin
        w = want[i - 1];
        checks++;
        if (data_out !== {w, w, w}) begin
          errors++;
          $display("FAIL modechange[%0d] got=%h want=%h", i - 1, data_out, {w, w, w});
        end
      end
    end
  endtask

  task automatic test_random();
    logic r, v, vis, sol, sof;
    drive(0, 1, 1, 1, 1, 2'($urandom_range(0, 3)), 24'($urandom));
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      vis = ($urandom_range(0, 7) != 0);
      sol = ($urandom_range(0, 5) == 0);
      sof = ($urandom_range(0, 39) == 0);
      drive(r, v, vis, sol, sof, 2'($urandom_range(0, 3)), 24'($urandom));
      checks++;
      if (out_valid !== exp_v || out_visible !== exp_s || data_out !== exp_d) begin
        errors++;
        $display("FAIL random[%0d] got v=%b s=%b d=%h want v=%b s=%b d=%h",
                 i, out_valid, out_visible, data_out, exp_v, exp_s, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_errdiff();
    test_ordered();
    test_saturation();
    test_gating();
    test_reset_midline();
    test_mode_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
